display_frame_loader: RTL

//  Write-side controller for the double-buffered display memory. Takes a byte stream
//  (valid/ready) carrying one full frame of 24-bit pixels, packs the bytes into pixels and

---
 rtl/display_frame_loader_pkg.sv | 18 +
 rtl/display_pixel_packer.sv | 62 ++++++
 rtl/display_frame_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/display_frame_loader_pkg.sv
// Shared geometry, pixel format and FSM encoding for the display frame loader.
package display_frame_loader_pkg;

   localparam int unsigned DefRows       = 8;
   localparam int unsigned DefColumns    = 32;
   localparam int unsigned DefRowW       = 3;
   localparam int unsigned DefColW       = 5;
   localparam int unsigned BytesPerPixel = 3;
   localparam int unsigned PixelW        = BytesPerPixel * 8;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StLoad     = 2'd1,
      StWaitSwap = 2'd2,
      StSwap     = 2'd3
   } state_e;

endpackage

// File: rtl/display_pixel_packer.sv
// Packs three consecutive bytes into one 24-bit pixel, byte k landing in bits [8k+7:8k].
module display_pixel_packer
   import display_frame_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_valid,
   input  logic              sof,
   input  logic              clr,
   input  logic [7:0]        byte_data,
   output logic              pixel_valid,
   output logic [PixelW-1:0] pixel,
   output logic [1:0]        byte_cnt
);

   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] pix_q, pix_d;

   // The third byte is presented directly so the pixel is complete in its handshake cycle.
   assign pixel    = {byte_data, pix_q};
   assign byte_cnt = cnt_q;

   always_comb begin
      cnt_d       = cnt_q;
      pix_d       = pix_q;
      pixel_valid = 1'b0;
      if (clr) begin
         cnt_d = 2'd0;
      end else if (byte_valid) begin
         if (sof) begin
            pix_d[7:0] = byte_data;
            cnt_d      = 2'd1;
         end else begin
            unique case (cnt_q)
               2'd0: begin
                  pix_d[7:0] = byte_data;
                  cnt_d      = 2'd1;
               end
               2'd1: begin
                  pix_d[15:8] = byte_data;
                  cnt_d       = 2'd2;
               end
               default: begin
                  pixel_valid = 1'b1;
                  cnt_d       = 2'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         pix_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
         pix_q <= pix_d;
      end
   end

endmodule

// File: rtl/display_frame_loader.sv
// Write-side controller of the double-buffered display memory: packs a byte stream into
// pixels, writes them in raster order and flips buffers on the driver's end-of-frame.
module display_frame_loader
   import display_frame_loader_pkg::*;
#(
   parameter int unsigned Rows    = DefRows,
   parameter int unsigned Columns = DefColumns,
   parameter int unsigned RowW    = DefRowW,
   parameter int unsigned ColW    = DefColW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_sof,
   input  logic              frame_end,
   output logic              mem_wen,
   output logic [RowW-1:0]   mem_irow,
   output logic [ColW-1:0]   mem_icol,
   output logic [PixelW-1:0] mem_i,
   output logic              mem_flip,
   output logic              frame_done,
   output logic              sync_err
);

   state_e              state_q, state_d;
   logic [RowW-1:0]     row_q, row_d;
   logic [ColW-1:0]     col_q, col_d;
   logic                mem_wen_q, mem_wen_d;
   logic [RowW-1:0]     irow_q, irow_d;
   logic [ColW-1:0]     icol_q, icol_d;
   logic [PixelW-1:0]   mem_i_q, mem_i_d;
   logic                flip_q, flip_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                hs;
   logic                pk_valid;
   logic                pk_clr;
   logic                pk_pixel_valid;
   logic [PixelW-1:0]   pk_pixel;
   logic [1:0]          pk_byte_cnt;
   logic                at_first;
   logic                last_col;
   logic                last_row;

   assign s_ready  = (state_q == StIdle) || (state_q == StLoad);
   assign hs       = s_valid & s_ready;
   // Idle bytes only reach the packer when they open a frame.
   assign pk_valid = hs & (s_sof | (state_q == StLoad));
   assign pk_clr   = (state_q == StSwap);
   assign at_first = (row_q == '0) && (col_q == '0) && (pk_byte_cnt == 2'd0);
   assign last_col = (col_q == ColW'(Columns - 1));
   assign last_row = (row_q == RowW'(Rows - 1));

   display_pixel_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_valid  (pk_valid),
      .sof         (s_sof),
      .clr         (pk_clr),
      .byte_data   (s_data),
      .pixel_valid (pk_pixel_valid),
      .pixel       (pk_pixel),
      .byte_cnt    (pk_byte_cnt)
   );

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      mem_wen_d = 1'b0;
      irow_d    = irow_q;
      icol_d    = icol_q;
      mem_i_d   = mem_i_q;
      flip_d    = flip_q;
      done_d    = 1'b0;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            if (hs && s_sof) begin
               state_d = StLoad;
               row_d   = '0;
               col_d   = '0;
            end
         end
         StLoad: begin
            if (hs && s_sof) begin
               if (!at_first) err_d = 1'b1;
               row_d = '0;
               col_d = '0;
            end else if (pk_pixel_valid) begin
               mem_wen_d = 1'b1;
               mem_i_d   = pk_pixel;
               irow_d    = row_q;
               icol_d    = col_q;
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     row_d   = '0;
                     state_d = StWaitSwap;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StWaitSwap: begin
            // Flip is registered on entry so it is visible during the SWAP cycle itself.
            if (frame_end) begin
               state_d = StSwap;
               flip_d  = ~flip_q;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            row_d   = '0;
            col_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         row_q     <= '0;
         col_q     <= '0;
         mem_wen_q <= 1'b0;
         irow_q    <= '0;
         icol_q    <= '0;
         mem_i_q   <= '0;
         flip_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         mem_wen_q <= mem_wen_d;
         irow_q    <= irow_d;
         icol_q    <= icol_d;
         mem_i_q   <= mem_i_d;
         flip_q    <= flip_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign mem_wen    = mem_wen_q;
   assign mem_irow   = irow_q;
   assign mem_icol   = icol_q;
   assign mem_i      = mem_i_q;
   assign mem_flip   = flip_q;
   assign frame_done = done_q;
   assign sync_err   = err_q;

endmodule
